// File: rtl/hash_des_stream.sv
// hash_des_stream: byte-stream hash built on the DES S5 box, with optional length finalization
module hash_des_stream #(
    parameter int ROUNDS   = 1,
    parameter int LEN_W    = 64,
    parameter int FINAL_EN = 1,
    parameter int ROT_MODE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             msg_valid,
    output logic             msg_ready,
    input  logic [7:0]       msg_byte,
    input  logic [LEN_W-1:0] len_in,
    output logic             hash_ready,
    output logic [31:0]      digest,
    output logic             len_err
);
    localparam int NB = LEN_W / 8;
    localparam logic [31:0] H_INIT = 32'h4B71DF03;
    // S5 rows 0..3 back to back, entry {row,col} = 0 in the top nibble
    localparam logic [255:0] S5 = {64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986,
                                   64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453};

    typedef enum logic [1:0] {IDLE, ABSORB, FINAL} state_t;

    state_t            state, state_n;
    logic [31:0]       h, hv, h_nx;
    logic [LEN_W-1:0]  rem, len_q, len_sh;
    logic [2:0]        fcnt;
    logic [7:0]        ab;
    logic [5:0]        idx;
    logic [3:0]        s;
    logic              take, done, drop;

    // one round: each nibble takes its right neighbour xor s, rotated/shifted by i/2
    function automatic logic [31:0] round_fn(input logic [31:0] hi, input logic [3:0] si);
        logic [3:0]  x;
        logic [7:0]  t;
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            x = hi[31-4*((i+1)%8) -: 4] ^ si;
            t = (ROT_MODE != 0) ? ({x, x} << (i/2)) : ({4'b0000, x} << (i/2));
            r[31-4*i -: 4] = (ROT_MODE != 0) ? t[7:4] : t[3:0];
        end
        return r;
    endfunction

    // byte reduction, S-box lookup and the chained rounds for the byte being absorbed
    always_comb begin
        len_sh = len_q >> {fcnt, 3'b000};
        ab     = (state == FINAL) ? len_sh[7:0] : msg_byte;
        idx    = {ab[3] ^ ab[2], ab[1], ab[0], ab[7], ab[6], ab[5] ^ ab[4]};
        s      = S5[{~{idx[5], idx[0], idx[4:1]}, 2'b00} +: 4];
        hv     = h;
        for (int r = 0; r < ROUNDS; r++) hv = round_fn(hv, s);
        h_nx   = hv;
    end

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // next state, handshake and absorb/complete strobes
    always_comb begin
        state_n   = state;
        msg_ready = (state != FINAL);
        take      = 1'b0;
        done      = 1'b0;
        drop      = 1'b0;
        case (state)
            IDLE: if (msg_valid) begin
                drop    = (len_in == '0);
                take    = !drop;
                done    = take && (len_in == LEN_W'(1)) && (FINAL_EN == 0);
                state_n = !take ? IDLE : (len_in != LEN_W'(1)) ? ABSORB : (FINAL_EN != 0) ? FINAL : IDLE;
            end
            ABSORB: if (msg_valid) begin
                take    = 1'b1;
                done    = (rem == LEN_W'(1)) && (FINAL_EN == 0);
                state_n = (rem != LEN_W'(1)) ? ABSORB : (FINAL_EN != 0) ? FINAL : IDLE;
            end
            FINAL: begin
                take    = 1'b1;
                done    = (fcnt == 3'(NB - 1));
                state_n = done ? IDLE : FINAL;
            end
            default: state_n = IDLE;
        endcase
    end

    // chaining state, length bookkeeping and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h          <= H_INIT;
            rem        <= '0;
            len_q      <= '0;
            fcnt       <= '0;
            digest     <= '0;
            hash_ready <= 1'b0;
            len_err    <= 1'b0;
        end else begin
            hash_ready <= done;
            len_err    <= drop;
            fcnt       <= (state == FINAL) ? fcnt + 3'd1 : 3'd0;
            if (take) h <= done ? H_INIT : h_nx;
            if (done) digest <= h_nx;
            if (take && state == IDLE) begin
                len_q <= len_in;
                rem   <= len_in - LEN_W'(1);
            end else if (take && state == ABSORB) begin
                rem   <= rem - LEN_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_hash_des_stream.sv
// tb_hash_des_stream: scoreboard bench over four configurations of hash_des_stream
module tb_hash_des_stream;
    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        msg_valid = 1'b0;
    logic [7:0]  msg_byte = 8'h00;
    logic [63:0] len_in = 64'd0;
    int          sel = 0;
    logic [3:0]  rdy, hr, le;
    logic [31:0] dg [4];

    int total = 0;
    int bad = 0;
    int lowcnt = 0;
    int lerr_exp [4] = '{0, 0, 0, 0};
    logic [31:0] exp_q [4][$];

    // per-instance configuration mirrored for the reference model
    int rounds_c [4] = '{1, 1, 1, 4};
    int rot_c    [4] = '{0, 1, 1, 1};
    int fin_c    [4] = '{0, 0, 1, 1};
    int lenw_c   [4] = '{64, 64, 64, 16};

    int s5t [4][16] = '{'{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9},
                        '{14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6},
                        '{4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14},
                        '{11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3}};

    always #5 clk = ~clk;

    hash_des_stream #(.ROUNDS(1), .LEN_W(64), .FINAL_EN(0), .ROT_MODE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .msg_valid(msg_valid && sel == 0), .msg_ready(rdy[0]),
        .msg_byte(msg_byte), .len_in(len_in), .hash_ready(hr[0]), .digest(dg[0]), .len_err(le[0]));
    hash_des_stream #(.ROUNDS(1), .LEN_W(64), .FINAL_EN(0), .ROT_MODE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .msg_valid(msg_valid && sel == 1), .msg_ready(rdy[1]),
        .msg_byte(msg_byte), .len_in(len_in), .hash_ready(hr[1]), .digest(dg[1]), .len_err(le[1]));
    hash_des_stream #(.ROUNDS(1), .LEN_W(64), .FINAL_EN(1), .ROT_MODE(1)) u2 (
        .clk(clk), .rst_n(rst_n), .msg_valid(msg_valid && sel == 2), .msg_ready(rdy[2]),
        .msg_byte(msg_byte), .len_in(len_in), .hash_ready(hr[2]), .digest(dg[2]), .len_err(le[2]));
    hash_des_stream #(.ROUNDS(4), .LEN_W(16), .FINAL_EN(1), .ROT_MODE(1)) u3 (
        .clk(clk), .rst_n(rst_n), .msg_valid(msg_valid && sel == 3), .msg_ready(rdy[3]),
        .msg_byte(msg_byte), .len_in(len_in[15:0]), .hash_ready(hr[3]), .digest(dg[3]), .len_err(le[3]));

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // one round-set of the hash on a byte, nibble by nibble
    function automatic logic [31:0] ref_byte(input logic [31:0] d, input logic [7:0] b, input int rot);
        int hn [8];
        int row, col, s, v, a;
        logic [31:0] r;
        for (int i = 0; i < 8; i++) hn[i] = int'(d[31-4*i -: 4]);
        row = 2 * int'(b[3] ^ b[2]) + int'(b[5] ^ b[4]);
        col = 8 * int'(b[1]) + 4 * int'(b[0]) + 2 * int'(b[7]) + int'(b[6]);
        s = s5t[row][col];
        r = 32'd0;
        for (int i = 0; i < 8; i++) begin
            v = hn[(i + 1) % 8] ^ s;
            a = i / 2;
            v = (rot != 0) ? (((v << a) | (v >> (4 - a))) & 15) : ((v << a) & 15);
            r = (r << 4) | 32'(v);
        end
        return r;
    endfunction

    function automatic logic [31:0] ref_hash(input bq_t m, input int k);
        logic [31:0] d;
        logic [63:0] len;
        d = 32'h4B71DF03;
        len = 64'(m.size());
        foreach (m[i]) for (int r = 0; r < rounds_c[k]; r++) d = ref_byte(d, m[i], rot_c[k]);
        if (fin_c[k] != 0)
            for (int j = 0; j < lenw_c[k] / 8; j++)
                for (int r = 0; r < rounds_c[k]; r++) d = ref_byte(d, 8'(len >> (8 * j)), rot_c[k]);
        return d;
    endfunction

    // offers one byte to instance k and returns on the negedge after it is taken
    task automatic send(input int k, input logic [7:0] b, input logic [63:0] len);
        int n = 0;
        sel = k;
        msg_byte = b;
        len_in = len;
        msg_valid = 1'b1;
        while (!rdy[k] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL send_timeout dut%0d: msg_ready got 0, expected 1", k);
        end
        @(negedge clk);
        msg_valid = 1'b0;
    endtask

    // bytes[8*i +: 8] is byte i; bmask bit i inserts a bubble after byte i; later bytes carry a junk len_in
    task automatic run_msg(input int k, input logic [79:0] bytes, input int n, input int bmask);
        bq_t m;
        for (int i = 0; i < n; i++) m.push_back(bytes[8*i +: 8]);
        exp_q[k].push_back(ref_hash(m, k));
        for (int i = 0; i < n; i++) begin
            send(k, m[i], (i == 0) ? 64'(n) : 64'hDEAD_BEEF_0000_0007);
            if (bmask[i]) @(negedge clk);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size() +
                lerr_exp[0] + lerr_exp[1] + lerr_exp[2] + lerr_exp[3]) != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
    endtask

    // monitor: every hash_ready / len_err pulse is matched against the scoreboard
    always @(negedge clk) begin
        if (!rdy[2]) lowcnt++;
        for (int k = 0; k < 4; k++) begin
            if (hr[k]) begin
                if (exp_q[k].size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_hash dut%0d: got pulse with digest %h, expected none", k, dg[k]);
                end else begin
                    check($sformatf("digest dut%0d", k), 64'(dg[k]), 64'(exp_q[k][0]));
                    void'(exp_q[k].pop_front());
                end
            end
            if (le[k]) begin
                check($sformatf("len_err_expected dut%0d", k), 64'(lerr_exp[k] > 0), 64'd1);
                if (lerr_exp[k] > 0) lerr_exp[k]--;
            end
        end
    end

    initial begin
        int lc;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("reset digest dut%0d", k), 64'(dg[k]), 64'd0);
            check($sformatf("reset hash_ready dut%0d", k), 64'(hr[k]), 64'd0);
            check($sformatf("reset len_err dut%0d", k), 64'(le[k]), 64'd0);
            check($sformatf("reset msg_ready dut%0d", k), 64'(rdy[k]), 64'd1);
        end

        // single zero byte, shift and rotate variants, result one cycle after transfer
        exp_q[0].push_back(32'h956E4880);
        send(0, 8'h00, 64'd1);
        check("latency dut0", 64'(hr[0]), 64'd1);
        exp_q[1].push_back(32'h956F7883);
        send(1, 8'h00, 64'd1);
        check("latency dut1", 64'(hr[1]), 64'd1);

        // zero-length first transfer is dropped and leaves H untouched
        lerr_exp[0]++;
        send(0, 8'h5A, 64'd0);
        check("len_err pulse dut0", 64'(le[0]), 64'd1);
        exp_q[0].push_back(32'h956E4880);
        send(0, 8'h00, 64'd1);
        repeat (4) @(negedge clk);
        check("digest hold dut0", 64'(dg[0]), 64'h956E4880);

        run_msg(0, 80'h636261, 3, 0);
        run_msg(1, 80'hFF80017F, 4, 'b10);
        drain();

        // five bytes with two bubbles, finalization holds msg_ready low for LEN_W/8 cycles
        lc = lowcnt;
        run_msg(2, 80'h5544332211, 5, 'b0101);
        drain();
        check("ready_low_cycles dut2", 64'(lowcnt - lc), 64'd8);

        // reset in the middle of a ten-byte message
        send(2, 8'h01, 64'd10);
        send(2, 8'h02, 64'd10);
        sel = 2;
        msg_byte = 8'h03;
        msg_valid = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        msg_valid = 1'b0;
        check("abort digest dut2", 64'(dg[2]), 64'd0);
        check("abort msg_ready dut2", 64'(rdy[2]), 64'd1);
        check("abort hash_ready dut2", 64'(hr[2]), 64'd0);
        repeat (15) @(negedge clk);
        check("abort digest held dut2", 64'(dg[2]), 64'd0);
        run_msg(2, 80'h0A090807060504030201, 10, 0);
        drain();

        // back-to-back messages with four rounds per byte
        run_msg(3, 80'hC0FFEE, 3, 0);
        run_msg(3, 80'h00A5, 2, 0);
        drain();

        for (int k = 0; k < 4; k++) begin
            check($sformatf("pending digests dut%0d", k), 64'(exp_q[k].size()), 64'd0);
            check($sformatf("pending len_err dut%0d", k), 64'(lerr_exp[k]), 64'd0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hash_des_stream.md
HASH_DES_STREAM -- requirements
Module: hash_des_stream

Interface
REQ-001 Parameter ROUNDS, default 1: S-box rounds chained per absorbed byte within one cycle; legal range 1..4.
REQ-002 Parameter LEN_W, default 64: width of message-length input; multiple of 8, range 8..64.
REQ-003 Parameter FINAL_EN, default 1: 1 = absorb the LEN_W/8 length bytes after the message; 0 = no finalization.
REQ-004 Parameter ROT_MODE, default 1: 1 = circular left rotate in round; 0 = logical left shift (legacy).
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 msg_valid  input  1  msg_byte/len_in valid this cycle.
REQ-008 msg_ready  output  1  block accepts a byte this cycle; transfer = msg_valid && msg_ready.
REQ-009 msg_byte  input  8  message byte.
REQ-010 len_in  input  LEN_W  message length in bytes, sampled only on the first transfer of a message.
REQ-011 hash_ready  output  1  one-cycle pulse, digest updated.
REQ-012 digest  output  32  hash result, held until next completion.
REQ-013 len_err  output  1  one-cycle pulse, zero-length first transfer dropped.

Function
REQ-014 Chaining state H[0..7], 4 bits each; init values 4,B,7,1,D,F,0,3 (hex).
REQ-015 Byte reduction: idx = {b[3]^b[2], b[1], b[0], b[7], b[6], b[5]^b[4]}.
REQ-016 S-box = DES S5 (standard table); row = {idx[5], idx[0]}, column = idx[4:1]; s = S5(idx).
REQ-017 One round: H'[i] = R(H[(i+1) mod 8] ^ s, floor(i/2)); R = rotate-left (ROT_MODE=1) or shift-left with zero fill, truncated to 4 bits (ROT_MODE=0).
REQ-018 Each absorbed byte applies ROUNDS rounds back-to-back with the same s, committed in one cycle.
REQ-019 FSM states IDLE, ABSORB, FINAL.
REQ-020 IDLE: msg_ready=1; transfer with len_in!=0 -> latch len_in, remaining=len_in-1, absorb byte; go ABSORB if remaining!=0, else FINAL (FINAL_EN=1) or complete (FINAL_EN=0).
REQ-021 IDLE: transfer with len_in==0 -> byte dropped, H unchanged, len_err pulses next cycle, stay IDLE.
REQ-022 ABSORB: msg_ready=1; each transfer absorbs byte, remaining decrements; on transfer with remaining==1 go FINAL or complete; msg_valid low = bubble, no state change.
REQ-023 FINAL: msg_ready=0; absorbs one latched-length byte per cycle, least-significant byte first, LEN_W/8 cycles, via same round logic.
REQ-024 Completion (end of last absorb cycle when FINAL_EN=0, else last FINAL cycle): digest <= {H'[0],...,H'[7]}, H'[0] in bits 31:28; hash_ready=1 next cycle; H reinitialised; state IDLE.
REQ-025 Latency: N-byte message without bubbles, first transfer cycle 0 -> hash_ready high in cycle N+LEN_W/8 (FINAL_EN=1) or cycle N (FINAL_EN=0).
REQ-026 Back-to-back: a transfer in the IDLE cycle coinciding with hash_ready starts the next message normally.
REQ-027 len_in changes after the first transfer are ignored; remaining counter is LEN_W bits, no wrap (len_in=2^LEN_W-1 legal).

Reset
REQ-028 rst_n low at a rising edge: state=IDLE, H=init, remaining=0, hash_ready=0, len_err=0, digest=0; msg_ready=1 from next cycle.
REQ-029 Reset mid-ABSORB or mid-FINAL aborts the message: no hash_ready, digest keeps 0, partial state discarded.

Verification
REQ-030 ROUNDS=1, FINAL_EN=0, ROT_MODE=0: single byte 0x00, len_in=1 -> hash_ready at cycle 1, digest=0x956E4880.
REQ-031 Same, ROT_MODE=1 -> digest=0x956F7883.
REQ-032 FINAL_EN=1, LEN_W=64, 5-byte message with two msg_valid bubbles -> msg_ready low for exactly 8 cycles, one hash_ready pulse, digest equals reference model.
REQ-033 IDLE transfer with len_in=0 -> len_err pulse, no H change; following len_in=1 message hashes as REQ-030.
REQ-034 rst_n low in 3rd byte of a 10-byte message -> outputs at reset values, no hash_ready; subsequent message matches model.
REQ-035 Two messages back-to-back (REQ-026), ROUNDS=4 -> two hash_ready pulses, each digest matching model independently.
